// File: rtl/spio_spinnaker_link_tx_arbiter_pkg.sv
// Shared definitions for the SpiNNaker link transmit arbiter.
// Packet width matches the sender's synchronous packet interface.
package spio_spinnaker_link_tx_arbiter_pkg;

  // Full (long-format) packet width carried between producers and the sender.
  localparam int PKT_BITS = 72;

  // Largest number of sources one arbiter instance is meant to serve.
  localparam int SPL_ARB_MAX_PORTS = 8;

  // Occupancy of the single registered output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/spio_rr_select.sv
// Round-robin selector: picks the first eligible source after the last grant,
// wrapping around, with the last-granted source considered last of all.
module spio_rr_select #(
  parameter int NUM_PORTS = 4,
  parameter int SEL_BITS  = 2
) (
  input  logic [NUM_PORTS-1:0] eligible,
  input  logic [SEL_BITS-1:0]  last,
  output logic [SEL_BITS-1:0]  winner,
  output logic                 any_eligible
);

  logic [SEL_BITS-1:0] cand;

  // Scan from furthest to nearest so the closest eligible source after 'last' wins.
  always_comb begin
    winner       = '0;
    any_eligible = 1'b0;
    cand         = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = SEL_BITS'((int'(last) + k) % NUM_PORTS);
      if (eligible[cand]) begin
        winner       = cand;
        any_eligible = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spio_spinnaker_link_tx_arbiter.sv
// Shares one SpiNNaker link sender among several packet sources using
// whole-packet round-robin arbitration into a single registered output slot.
// The slot may reload in the same cycle the sender empties it.
module spio_spinnaker_link_tx_arbiter
  import spio_spinnaker_link_tx_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int SEL_BITS  = 2
) (
  input  logic                          CLK_IN,
  input  logic                          RESET_IN,
  input  logic [NUM_PORTS-1:0]          PORT_EN_IN,
  input  logic [NUM_PORTS*PKT_BITS-1:0] REQ_DATA_IN,
  input  logic [NUM_PORTS-1:0]          REQ_VLD_IN,
  output logic [NUM_PORTS-1:0]          REQ_RDY_OUT,
  output logic [PKT_BITS-1:0]           PKT_DATA_OUT,
  output logic                          PKT_VLD_OUT,
  input  logic                          PKT_RDY_IN,
  output logic [SEL_BITS-1:0]           GRANT_OUT,
  output logic                          BUSY_OUT
);

  slot_state_t         state_q;
  slot_state_t         state_d;
  logic [SEL_BITS-1:0] last_q;
  logic [NUM_PORTS-1:0] eligible;
  logic [SEL_BITS-1:0] winner;
  logic                any_eligible;
  logic                slot_free;
  logic                src_xfer;

  assign eligible = REQ_VLD_IN & PORT_EN_IN;

  spio_rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_BITS  (SEL_BITS)
  ) u_rr_select (
    .eligible     (eligible),
    .last         (last_q),
    .winner       (winner),
    .any_eligible (any_eligible)
  );

  // The slot can take a packet when empty or when the sender is draining it this cycle;
  // nothing is accepted while reset is held so a source never sees a phantom handshake.
  assign slot_free = (state_q == SLOT_EMPTY) | PKT_RDY_IN;
  assign src_xfer  = RESET_IN & slot_free & any_eligible;

  // Only the current winner is offered ready, which keeps the ready mask one-hot.
  always_comb begin
    REQ_RDY_OUT = '0;
    if (src_xfer) begin
      REQ_RDY_OUT[winner] = 1'b1;
    end
  end

  // Slot occupancy: fill on a source transfer, empty on sender accept without reload.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (src_xfer) state_d = SLOT_FULL;
      SLOT_FULL:  if (PKT_RDY_IN && !src_xfer) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  // Slot occupancy register; reset drops any held packet.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q <= SLOT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the granted packet and its source; pointer reset makes port 0 first in line.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      PKT_DATA_OUT <= '0;
      GRANT_OUT    <= '0;
      last_q       <= SEL_BITS'(NUM_PORTS - 1);
    end else if (src_xfer) begin
      PKT_DATA_OUT <= REQ_DATA_IN[int'(winner)*PKT_BITS +: PKT_BITS];
      GRANT_OUT    <= winner;
      last_q       <= winner;
    end
  end

  assign PKT_VLD_OUT = (state_q == SLOT_FULL);
  assign BUSY_OUT    = PKT_VLD_OUT;

endmodule

// File: tb/tb_spio_spinnaker_link_tx_arbiter.sv
// Directed bench for the link transmit arbiter: reset, fairness, backpressure,
// masking, sparse wrap-around, drain and reset while a packet is held.
module tb_spio_spinnaker_link_tx_arbiter;
  import spio_spinnaker_link_tx_arbiter_pkg::*;

  localparam int NUM_PORTS = 4;
  localparam int SEL_BITS  = 2;

  logic                          CLK_IN = 1'b0;
  logic                          RESET_IN;
  logic [NUM_PORTS-1:0]          PORT_EN_IN;
  logic [NUM_PORTS*PKT_BITS-1:0] REQ_DATA_IN;
  logic [NUM_PORTS-1:0]          REQ_VLD_IN;
  logic [NUM_PORTS-1:0]          REQ_RDY_OUT;
  logic [PKT_BITS-1:0]           PKT_DATA_OUT;
  logic                          PKT_VLD_OUT;
  logic                          PKT_RDY_IN;
  logic [SEL_BITS-1:0]           GRANT_OUT;
  logic                          BUSY_OUT;

  int vectors     = 0;
  int miscompares = 0;

  spio_spinnaker_link_tx_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_BITS  (SEL_BITS)
  ) dut (
    .CLK_IN       (CLK_IN),
    .RESET_IN     (RESET_IN),
    .PORT_EN_IN   (PORT_EN_IN),
    .REQ_DATA_IN  (REQ_DATA_IN),
    .REQ_VLD_IN   (REQ_VLD_IN),
    .REQ_RDY_OUT  (REQ_RDY_OUT),
    .PKT_DATA_OUT (PKT_DATA_OUT),
    .PKT_VLD_OUT  (PKT_VLD_OUT),
    .PKT_RDY_IN   (PKT_RDY_IN),
    .GRANT_OUT    (GRANT_OUT),
    .BUSY_OUT     (BUSY_OUT)
  );

  // 10 ns clock.
  always #5 CLK_IN = ~CLK_IN;

  task automatic checkValue(input string tag, input logic [PKT_BITS-1:0] observed,
                            input logic [PKT_BITS-1:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_vld,
                             input logic [SEL_BITS-1:0] exp_grant,
                             input logic [PKT_BITS-1:0] exp_data);
    checkValue({tag, "_vld"},   PKT_BITS'(PKT_VLD_OUT), PKT_BITS'(exp_vld));
    checkValue({tag, "_busy"},  PKT_BITS'(BUSY_OUT),    PKT_BITS'(exp_vld));
    checkValue({tag, "_grant"}, PKT_BITS'(GRANT_OUT),   PKT_BITS'(exp_grant));
    checkValue({tag, "_data"},  PKT_DATA_OUT,           exp_data);
  endtask

  task automatic checkReady(input string tag, input logic [NUM_PORTS-1:0] exp_rdy);
    checkValue({tag, "_rdy"}, PKT_BITS'(REQ_RDY_OUT), PKT_BITS'(exp_rdy));
  endtask

  task automatic applyStimulus(input logic [NUM_PORTS-1:0] vld,
                               input logic [NUM_PORTS-1:0] en, input logic rdy);
    REQ_VLD_IN = vld;
    PORT_EN_IN = en;
    PKT_RDY_IN = rdy;
  endtask

  task automatic nextEdge();
    @(posedge CLK_IN);
    #1;
  endtask

  initial begin
    logic [SEL_BITS-1:0] g;
    for (int i = 0; i < NUM_PORTS; i++) begin
      REQ_DATA_IN[i*PKT_BITS +: PKT_BITS] = PKT_BITS'(72'h1000 + PKT_BITS'(i));
    end
    $display("[TB] start");

    // Reset held with every source requesting: nothing ready, slot empty.
    RESET_IN = 1'b0;
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    repeat (2) @(posedge CLK_IN);
    #1;
    checkOutput("reset", 1'b0, 2'd0, 72'h0);
    checkReady("reset", 4'b0000);

    // Release with sender ready: port 0 first, then strict rotation, one per cycle.
    RESET_IN = 1'b1;
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    #1;
    for (int k = 0; k < 8; k++) begin
      g = SEL_BITS'(k % 4);
      checkReady("fair", 4'(1 << g));
      nextEdge();
      checkOutput("fair", 1'b1, g, 72'h1000 + PKT_BITS'(g));
      #1;
    end

    // Sender stalls with port 3's packet held: slot frozen, no source ready.
    applyStimulus(4'b1111, 4'b1111, 1'b0);
    for (int k = 0; k < 20; k++) begin
      #1;
      checkReady("bp", 4'b0000);
      nextEdge();
      checkOutput("bp", 1'b1, 2'd3, 72'h1003);
    end

    // Sender resumes: reload in the same cycle, no bubble.
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    #1;
    checkReady("bp_release", 4'b0001);
    nextEdge();
    checkOutput("bp_release", 1'b1, 2'd0, 72'h1000);

    // Only ports 1 and 3 enabled: grants alternate 1,3,1,3.
    applyStimulus(4'b1111, 4'b1010, 1'b1);
    #1;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2'd1 : 2'd3;
      checkReady("mask", 4'(1 << g));
      nextEdge();
      checkOutput("mask", 1'b1, g, 72'h1000 + PKT_BITS'(g));
      #1;
    end

    // Last grant was 3, only port 2 valid: wrap finds port 2.
    applyStimulus(4'b0100, 4'b1111, 1'b1);
    #1;
    checkReady("sparse2", 4'b0100);
    nextEdge();
    checkOutput("sparse2", 1'b1, 2'd2, 72'h1002);

    // Ports 2 and 3 valid after granting 2: port 3 is next.
    applyStimulus(4'b1100, 4'b1111, 1'b1);
    #1;
    checkReady("sparse3", 4'b1000);
    nextEdge();
    checkOutput("sparse3", 1'b1, 2'd3, 72'h1003);

    // No requests: sender drains the slot, data and grant hold.
    applyStimulus(4'b0000, 4'b1111, 1'b1);
    #1;
    checkReady("drain", 4'b0000);
    nextEdge();
    checkOutput("drain", 1'b0, 2'd3, 72'h1003);

    // Disabled port requesting is never made ready.
    applyStimulus(4'b0001, 4'b1110, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkReady("disabled", 4'b0000);
      nextEdge();
      checkOutput("disabled", 1'b0, 2'd3, 72'h1003);
    end

    // Empty slot accepts even while the sender is not ready, then holds.
    applyStimulus(4'b0010, 4'b1111, 1'b0);
    #1;
    checkReady("fill", 4'b0010);
    nextEdge();
    checkOutput("fill", 1'b1, 2'd1, 72'h1001);
    #1;
    checkReady("fill_hold", 4'b0000);

    // Reset while a packet is held: everything cleared immediately.
    RESET_IN = 1'b0;
    #1;
    checkOutput("midreset", 1'b0, 2'd0, 72'h0);
    checkReady("midreset", 4'b0000);
    applyStimulus(4'b1111, 4'b1111, 1'b1);
    nextEdge();
    checkOutput("midreset_hold", 1'b0, 2'd0, 72'h0);
    checkReady("midreset_hold", 4'b0000);

    // After release the pointer restarts so port 0 wins again.
    RESET_IN = 1'b1;
    #1;
    checkReady("post_reset", 4'b0001);
    nextEdge();
    checkOutput("post_reset", 1'b1, 2'd0, 72'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
